// File: rtl/axi_lite_master_p.sv
// AXI4-Lite master: turns single core-side valid/ready requests into AXI4-Lite
// read or write transactions, reports the response and aborts hung transfers.
module axi_lite_master_p #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [ADDR_W-1:0]     req_addr_i,
    input  logic [DATA_W-1:0]     req_wdata_i,
    input  logic [DATA_W/8-1:0]   req_wstrb_i,
    output logic                  rsp_valid_o,
    output logic [DATA_W-1:0]     rsp_rdata_o,
    output logic [1:0]            rsp_resp_o,
    output logic                  rsp_timeout_o,
    output logic                  arvalid_o,
    input  logic                  arready_i,
    output logic [ADDR_W-1:0]     araddr_o,
    input  logic                  rvalid_i,
    output logic                  rready_o,
    input  logic [DATA_W-1:0]     rdata_i,
    input  logic [1:0]            rresp_i,
    output logic                  awvalid_o,
    input  logic                  awready_i,
    output logic [ADDR_W-1:0]     awaddr_o,
    output logic                  wvalid_o,
    input  logic                  wready_i,
    output logic [DATA_W-1:0]     wdata_o,
    output logic [DATA_W/8-1:0]   wstrb_o,
    input  logic                  bvalid_i,
    output logic                  bready_o,
    input  logic [1:0]            bresp_i
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_A    = 3'd1,
        S_RD_D    = 3'd2,
        S_WR_AW_W = 3'd3,
        S_WR_B    = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    localparam bit               LP_WD_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] LP_LAST  = LP_WD_EN ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] LP_ONE   = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_aw_done;
    logic             r_w_done;

    logic             w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs;
    logic             w_aw_ok, w_w_ok;
    logic             w_busy, w_phase_done, w_abort;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_ar_hs = arvalid_o & arready_i;
    assign w_r_hs  = rvalid_i  & rready_o;
    assign w_aw_hs = awvalid_o & awready_i;
    assign w_w_hs  = wvalid_o  & wready_i;
    assign w_b_hs  = bvalid_i  & bready_o;
    assign w_aw_ok = r_aw_done | w_aw_hs;
    assign w_w_ok  = r_w_done  | w_w_hs;

    // Saturating count, so a phase entered past the limit still expires
    assign w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + LP_ONE;

    // Decide whether the current phase completes and whether the watchdog fires
    always_comb begin
        w_busy       = 1'b1;
        w_phase_done = 1'b0;
        case (r_state)
            S_RD_A:    w_phase_done = w_ar_hs;
            S_RD_D:    w_phase_done = w_r_hs;
            S_WR_AW_W: w_phase_done = w_aw_ok & w_w_ok;
            S_WR_B:    w_phase_done = w_b_hs;
            default:   w_busy       = 1'b0;
        endcase
        if (LP_WD_EN && w_busy && !w_phase_done && (r_cnt >= LP_LAST)) begin
            w_abort = 1'b1;
        end else begin
            w_abort = 1'b0;
        end
    end

    // Transaction FSM with all outputs registered
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            req_ready_o   <= 1'b0;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_resp_o    <= 2'b00;
            rsp_timeout_o <= 1'b0;
            arvalid_o     <= 1'b0;
            araddr_o      <= '0;
            rready_o      <= 1'b0;
            awvalid_o     <= 1'b0;
            awaddr_o      <= '0;
            wvalid_o      <= 1'b0;
            wdata_o       <= '0;
            wstrb_o       <= '0;
            bready_o      <= 1'b0;
        end else begin
            rsp_valid_o <= 1'b0;
            if (w_busy) begin
                r_cnt <= w_cnt_nxt;
            end
            if (w_abort) begin
                // Recovery path: every handshake signal drops at once
                arvalid_o     <= 1'b0;
                rready_o      <= 1'b0;
                awvalid_o     <= 1'b0;
                wvalid_o      <= 1'b0;
                bready_o      <= 1'b0;
                rsp_valid_o   <= 1'b1;
                rsp_resp_o    <= 2'b10;
                rsp_timeout_o <= 1'b1;
                r_state       <= S_RESP;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        req_ready_o <= 1'b1;
                        if (req_valid_i && req_ready_o) begin
                            req_ready_o <= 1'b0;
                            araddr_o    <= req_addr_i;
                            awaddr_o    <= req_addr_i;
                            wdata_o     <= req_wdata_i;
                            wstrb_o     <= req_wstrb_i;
                            r_cnt       <= '0;
                            r_aw_done   <= 1'b0;
                            r_w_done    <= 1'b0;
                            if (req_write_i) begin
                                awvalid_o <= 1'b1;
                                wvalid_o  <= 1'b1;
                                r_state   <= S_WR_AW_W;
                            end else begin
                                arvalid_o <= 1'b1;
                                r_state   <= S_RD_A;
                            end
                        end
                    end
                    S_RD_A: begin
                        if (w_ar_hs) begin
                            arvalid_o <= 1'b0;
                            rready_o  <= 1'b1;
                            r_state   <= S_RD_D;
                        end
                    end
                    S_RD_D: begin
                        if (w_r_hs) begin
                            rready_o      <= 1'b0;
                            rsp_rdata_o   <= rdata_i;
                            rsp_resp_o    <= rresp_i;
                            rsp_timeout_o <= 1'b0;
                            rsp_valid_o   <= 1'b1;
                            r_state       <= S_RESP;
                        end
                    end
                    S_WR_AW_W: begin
                        if (w_aw_ok && w_w_ok) begin
                            awvalid_o <= 1'b0;
                            wvalid_o  <= 1'b0;
                            bready_o  <= 1'b1;
                            r_state   <= S_WR_B;
                        end else begin
                            if (w_aw_hs) begin
                                awvalid_o <= 1'b0;
                                r_aw_done <= 1'b1;
                            end
                            if (w_w_hs) begin
                                wvalid_o <= 1'b0;
                                r_w_done <= 1'b1;
                            end
                        end
                    end
                    S_WR_B: begin
                        if (w_b_hs) begin
                            bready_o      <= 1'b0;
                            rsp_resp_o    <= bresp_i;
                            rsp_timeout_o <= 1'b0;
                            rsp_valid_o   <= 1'b1;
                            r_state       <= S_RESP;
                        end
                    end
                    S_RESP: begin
                        rsp_timeout_o <= 1'b0;
                        req_ready_o   <= 1'b1;
                        r_state       <= S_IDLE;
                    end
                    default: begin
                        arvalid_o <= 1'b0;
                        rready_o  <= 1'b0;
                        awvalid_o <= 1'b0;
                        wvalid_o  <= 1'b0;
                        bready_o  <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_master_p.sv
// Directed bench for axi_lite_master_p: zero-wait vector table plus hand-built
// sequences for split write handshakes, watchdog expiry and mid-transfer reset.
module tb_axi_lite_master_p;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i, req_ready_o, req_write_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic [3:0]  req_wstrb_i;
    logic        rsp_valid_o, rsp_timeout_o;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  rsp_resp_o;
    logic        arvalid_o, arready_i;
    logic [31:0] araddr_o;
    logic        rvalid_i, rready_o;
    logic [31:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        awvalid_o, awready_i;
    logic [31:0] awaddr_o;
    logic        wvalid_o, wready_i;
    logic [31:0] wdata_o;
    logic [3:0]  wstrb_o;
    logic        bvalid_i, bready_o;
    logic [1:0]  bresp_i;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] sdata;
        logic [1:0]  sresp;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[6];

    axi_lite_master_p #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_resp_o(rsp_resp_o),
        .rsp_timeout_o(rsp_timeout_o),
        .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o),
        .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i), .rresp_i(rresp_i),
        .awvalid_o(awvalid_o), .awready_i(awready_i), .awaddr_o(awaddr_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
        .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL global_timeout: got stuck want finish");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] ctl_bits();
        return {req_ready_o, rsp_valid_o, rsp_timeout_o, arvalid_o,
                rready_o, awvalid_o, wvalid_o, bready_o};
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!req_ready_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check("req_ready_wait", req_ready_o, 1);
    endtask

    // Present one request, hold it through the accepting edge, land on the next negedge
    task automatic issue(input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
        wait_ready();
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_wstrb_i = wstrb;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        check("req_ready_busy", req_ready_o, 0);
    endtask

    task automatic run_vec(input vec_t v);
        issue(v.wr, v.addr, v.wdata, v.wstrb);
        if (!v.wr) begin
            check("arvalid_n1", arvalid_o, 1);
            check("araddr", araddr_o, v.addr);
            arready_i = 1'b1;
            @(negedge clk_i);
            arready_i = 1'b0;
            check("arvalid_drop", arvalid_o, 0);
            check("rready_up", rready_o, 1);
            rvalid_i = 1'b1;
            rdata_i  = v.sdata;
            rresp_i  = v.sresp;
            @(negedge clk_i);
            rvalid_i = 1'b0;
        end else begin
            check("aw_w_valid_n1", {awvalid_o, wvalid_o}, 2'b11);
            check("awaddr", awaddr_o, v.addr);
            check("wdata", wdata_o, v.wdata);
            check("wstrb", wstrb_o, v.wstrb);
            awready_i = 1'b1;
            wready_i  = 1'b1;
            @(negedge clk_i);
            awready_i = 1'b0;
            wready_i  = 1'b0;
            check("aw_w_drop", {awvalid_o, wvalid_o}, 2'b00);
            check("bready_up", bready_o, 1);
            bvalid_i = 1'b1;
            bresp_i  = v.sresp;
            @(negedge clk_i);
            bvalid_i = 1'b0;
        end
        check("rsp_valid_n3", rsp_valid_o, 1);
        check("rsp_rdata", rsp_rdata_o, v.exp_rdata);
        check("rsp_resp", rsp_resp_o, v.exp_resp);
        check("rsp_timeout", rsp_timeout_o, 0);
        check("ready_low_in_resp", {rready_o, bready_o}, 2'b00);
        @(negedge clk_i);
        check("rsp_pulse_end", rsp_valid_o, 0);
        check("req_ready_n4", req_ready_o, 1);
    endtask

    initial begin
        int   hi;
        bit   seen;
        vec_t v;

        vecs[0] = '{1'b0, 32'h0000_1004, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 2'b00};
        vecs[1] = '{1'b1, 32'h0000_2000, 32'h1234_5678, 4'hF, 32'h0, 2'b00, 32'hDEAD_BEEF, 2'b00};
        vecs[2] = '{1'b1, 32'h0000_2004, 32'hA5A5_A5A5, 4'b0011, 32'h0, 2'b10, 32'hDEAD_BEEF, 2'b10};
        vecs[3] = '{1'b0, 32'h0000_3008, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b01, 32'hCAFE_F00D, 2'b01};
        vecs[4] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'b1000, 32'h0, 2'b11, 32'hCAFE_F00D, 2'b11};
        vecs[5] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 32'h0000_0000, 2'b11, 32'h0000_0000, 2'b11};

        rst_i = 1'b1;
        req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0; req_wdata_i = '0; req_wstrb_i = '0;
        arready_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; rresp_i = 2'b00;
        awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0; bresp_i = 2'b00;
        @(negedge clk_i);
        @(negedge clk_i);
        check("reset_ctl", ctl_bits(), 8'h00);
        check("reset_data", {rsp_rdata_o, rsp_resp_o, araddr_o[15:0], wstrb_o}, 54'h0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("ready_after_reset", req_ready_o, 1);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Write where AW is accepted three cycles ahead of W
        issue(1'b1, 32'h0000_4000, 32'h1234_5678, 4'b0011);
        check("split_w_data", {wdata_o, wstrb_o}, {32'h1234_5678, 4'b0011});
        awready_i = 1'b1;
        @(negedge clk_i);
        awready_i = 1'b0;
        check("split_aw_drop", {awvalid_o, wvalid_o, bready_o}, 3'b010);
        @(negedge clk_i);
        check("split_wait1", {awvalid_o, wvalid_o, bready_o}, 3'b010);
        check("split_w_stable", {wdata_o, wstrb_o}, {32'h1234_5678, 4'b0011});
        @(negedge clk_i);
        check("split_wait2", {awvalid_o, wvalid_o, bready_o}, 3'b010);
        wready_i = 1'b1;
        @(negedge clk_i);
        wready_i = 1'b0;
        check("split_bready", {awvalid_o, wvalid_o, bready_o}, 3'b001);
        bvalid_i = 1'b1;
        bresp_i  = 2'b00;
        @(negedge clk_i);
        bvalid_i = 1'b0;
        check("split_rsp", {rsp_valid_o, rsp_timeout_o, rsp_resp_o}, 4'b1000);

        // Watchdog expiry with arready never asserted
        issue(1'b0, 32'h0000_5000, 32'h0, 4'h0);
        hi = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (rsp_valid_o) begin
                seen = 1'b1;
            end else begin
                if (arvalid_o) hi++;
                @(negedge clk_i);
            end
        end
        check("wd_seen", seen, 1);
        check("wd_arvalid_cycles", hi, 8);
        check("wd_rsp", {rsp_resp_o, rsp_timeout_o, arvalid_o, rready_o}, 5'b10100);
        @(negedge clk_i);
        check("wd_timeout_clears", {rsp_valid_o, rsp_timeout_o}, 2'b00);
        rvalid_i = 1'b1;
        rdata_i  = 32'hBAD0_BAD0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("wd_late_rvalid", {rsp_valid_o, rready_o}, 2'b00);
        end
        rvalid_i = 1'b0;
        check("wd_rdata_kept", rsp_rdata_o, 32'h0000_0000);

        // arready arrives in the last allowed cycle: handshake beats the watchdog
        issue(1'b0, 32'h0000_6000, 32'h0, 4'h0);
        for (int i = 1; i < 8; i++) @(negedge clk_i);
        check("edge_arvalid_c8", arvalid_o, 1);
        arready_i = 1'b1;
        @(negedge clk_i);
        arready_i = 1'b0;
        check("edge_rd_d", {arvalid_o, rready_o, rsp_valid_o}, 3'b010);
        rvalid_i = 1'b1;
        rdata_i  = 32'h600D_F00D;
        rresp_i  = 2'b00;
        @(negedge clk_i);
        rvalid_i = 1'b0;
        check("edge_rsp", {rsp_valid_o, rsp_timeout_o, rsp_resp_o}, 4'b1000);
        check("edge_rdata", rsp_rdata_o, 32'h600D_F00D);

        // Asynchronous reset while waiting in the data phase
        issue(1'b0, 32'h0000_7000, 32'h0, 4'h0);
        arready_i = 1'b1;
        @(negedge clk_i);
        arready_i = 1'b0;
        check("rst_pre_rready", rready_o, 1);
        rvalid_i = 1'b1;
        rdata_i  = 32'h57A1_E000;
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_async_ctl", ctl_bits(), 8'h00);
        check("rst_async_data", {rsp_rdata_o, rsp_resp_o}, 34'h0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i    = 1'b0;
        rvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("rst_no_stale_rsp", rsp_valid_o, 0);
        end
        v = '{1'b0, 32'h0000_1004, 32'h0, 4'h0, 32'h1357_9BDF, 2'b00, 32'h1357_9BDF, 2'b00};
        run_vec(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_lite_master_p.md
Name: axi_lite_master_p

Overview:
- Parametrised AXI4-Lite master bridging the core-side request/response interface onto one AXI4-Lite port.
- Successor of the fixed 32-bit handshake master. Adds:
  - configurable address and data width
  - byte write strobes
  - level-based valid/ready request handshake, replacing edge detection
  - explicit response reporting with RRESP/BRESP passthrough
  - a programmable bus-timeout watchdog
- Sits between the CPU load/store unit or DMA and the interconnect.

Parameters:
- ADDR_W, 32, address width of request and AW/AR channels.
- DATA_W, 32, data width; must be 32 or 64; STRB_W = DATA_W/8.
- TIMEOUT, 1024, cycles allowed per transaction before abort; 0 disables the watchdog.
- CNT_W, 16, width of the timeout counter; TIMEOUT must fit in CNT_W bits.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when req_valid_i && req_ready_o.
- req_write_i  in  1  1 = write, 0 = read.
- req_addr_i  in  ADDR_W  byte address.
- req_wdata_i  in  DATA_W  write data.
- req_wstrb_i  in  STRB_W  write byte strobes.
- rsp_valid_o  out  1  one-cycle pulse marking transaction completion.
- rsp_rdata_o  out  DATA_W  read data; holds its value until the next read completes.
- rsp_resp_o  out  2  AXI response code of the completed transaction.
- rsp_timeout_o  out  1  completion was caused by the watchdog (valid with rsp_valid_o).
- arvalid_o / arready_i / araddr_o  out / in / out  1 / 1 / ADDR_W  AR channel.
- rvalid_i / rready_o / rdata_i / rresp_i  in / out / in / in  1 / 1 / DATA_W / 2  R channel.
- awvalid_o / awready_i / awaddr_o  out / in / out  1 / 1 / ADDR_W  AW channel.
- wvalid_o / wready_i / wdata_o / wstrb_o  out / in / out / out  1 / 1 / DATA_W / STRB_W  W channel.
- bvalid_i / bready_o / bresp_i  in / out / in  1 / 1 / 2  B channel.

Behaviour:
- Reset: all outputs registered and driven to 0 (req_ready_o = 0 during reset); FSM enters IDLE; counter cleared. Async assert, sync release. Reset mid-transaction drops every valid/ready immediately and issues no response.
- FSM states: IDLE, RD_A, RD_D, WR_AW_W, WR_B, RESP.
- IDLE:
  - req_ready_o = 1.
  - On accept: latch addr, wdata, wstrb and write flag.
  - Read goes to RD_A with arvalid_o = 1 in the next cycle.
  - Write goes to WR_AW_W with awvalid_o = wvalid_o = 1 in the next cycle.
  - req_ready_o is low in every other state.
- RD_A: hold arvalid_o and araddr_o stable until arready_i is sampled high. Then drop arvalid_o, raise rready_o, go to RD_D.
- RD_D: on rvalid_i && rready_o, capture rdata_i and rresp_i, drop rready_o, go to RESP.
- WR_AW_W:
  - aw_done and w_done flags track each channel independently.
  - awvalid_o drops the cycle after its handshake; wvalid_o likewise.
  - A simultaneous handshake on both channels sets both flags in the same cycle.
  - When both flags are set (including the same cycle), raise bready_o and go to WR_B.
- WR_B: on bvalid_i, capture bresp_i, drop bready_o, go to RESP.
- RESP:
  - rsp_valid_o = 1 for exactly one cycle, then IDLE.
  - Back-to-back minimum request-to-request interval = 4 cycles for a zero-wait-state slave.
  - rsp_rdata_o is updated on reads only.
  - rsp_resp_o = captured RRESP/BRESP.
- Latency, zero-wait slave:
  - Accept at cycle N; arvalid_o at N+1; R handshake at N+2; rsp_valid_o at N+3.
  - Writes: AW/W at N+1; B at N+2; rsp_valid_o at N+3.
- Watchdog (TIMEOUT > 0):
  - Counter clears on entry to RD_A/WR_AW_W and increments every cycle in RD_A, RD_D, WR_AW_W, WR_B.
  - When count == TIMEOUT - 1 and the current phase's handshake does not complete that cycle:
    - abort: drop all valid/ready outputs next cycle;
    - go to RESP with rsp_resp_o = 2'b10 (SLVERR) and rsp_timeout_o = 1.
  - A handshake completing in the same cycle as expiry wins; no timeout is reported.
  - After an abort, late rvalid_i/bvalid_i are ignored, since rready_o and bready_o are low.
- AXI rules:
  - Valid never depends combinationally on ready.
  - Address, data and strobe are stable while valid is high.
  - The exception is the watchdog abort, a documented recovery-only violation.

Test Plan:
- Read, zero-wait slave, addr 0x0000_1004, rdata 0xDEAD_BEEF, RRESP 00 -> araddr_o = 0x1004 at N+1, rsp_valid_o pulse at N+3, rsp_rdata_o = 0xDEADBEEF, rsp_resp_o = 00.
- Write 0x1234_5678, wstrb 4'b0011; slave returns awready 3 cycles before wready -> awvalid_o drops after its handshake while wvalid_o stays high; bready_o rises only after W completes; rsp_resp_o = 00.
- Write with awready_i and wready_i high in the same cycle, BRESP = 2'b10 -> single move to WR_B, rsp_resp_o = 10, rsp_timeout_o = 0.
- TIMEOUT = 8, arready_i held low -> arvalid_o high for exactly 8 cycles, then low; rsp_valid_o with resp 10 and rsp_timeout_o = 1; a later rvalid_i produces no response.
- Edge of the watchdog: arready_i rises exactly on cycle 8 -> normal read completes, rsp_timeout_o = 0.
- rst_i asserted while in RD_D with rready_o high -> all outputs 0 asynchronously; after release, a new read request completes normally with no stale response.
